// File: rtl/lstm_weight_update_if.sv
// Gradient, preload and sweep-control bundle of the LSTM weight-update engine.
interface lstm_weight_update_if #(
  parameter int DATA_W  = 32,
  parameter int N_PARAM = 12
);
  logic                        grad_valid;
  logic                        grad_ready;
  logic [3:0]                  grad_idx;
  logic [DATA_W-1:0]           grad_data;
  logic                        load_valid;
  logic [3:0]                  load_idx;
  logic [DATA_W-1:0]           load_data;
  logic [DATA_W-1:0]           lr;
  logic                        apply_req;
  logic [N_PARAM*DATA_W-1:0]   param_flat;
  logic                        busy;
  logic                        done;
  logic                        err_idx;
  logic [15:0]                 grad_count;

  modport master (
    output grad_valid, grad_idx, grad_data, load_valid, load_idx, load_data, lr, apply_req,
    input  grad_ready, param_flat, busy, done, err_idx, grad_count
  );
  modport slave (
    input  grad_valid, grad_idx, grad_data, load_valid, load_idx, load_data, lr, apply_req,
    output grad_ready, param_flat, busy, done, err_idx, grad_count
  );
endinterface

// File: rtl/lstm_weight_update.sv
// Accumulates Q16.16 gradients per LSTM parameter and applies param -= lr*acc in a 2-stage sweep.
// Define LSTM_WU_SAT_EN to saturate accumulate/narrow/subtract instead of wrapping.
module lstm_weight_update #(
  parameter int DATA_W  = 32,
  parameter int FRAC    = 16,
  parameter int N_PARAM = 12
) (
  input  logic clk,
  input  logic rst,
  lstm_weight_update_if.slave bus
);
`ifdef LSTM_WU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic [3:0]        NP   = 4'(N_PARAM);
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, APPLY} state_t;

  state_t                           state_q, state_d;
  logic [N_PARAM-1:0][DATA_W-1:0]   param_q, acc_q;
  logic [15:0]                      gcnt_q;
  logic [3:0]                       cnt_q, widx_q, k_rd;
  logic [DATA_W-1:0]                p_q, p_d;
  logic [2*DATA_W-1:0]              prod;
  logic                             s1_vld_q, done_q, err_q;
  logic                             grad_acc, grad_ok, s1_go, sweep_end;

  // One extra sign bit carries the overflow information for add/sub.
  function automatic logic [DATA_W-1:0] fit(input logic [DATA_W:0] s);
    if (SAT_EN && (s[DATA_W] != s[DATA_W-1])) return s[DATA_W] ? MINV : MAXV;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] narrow(input logic signed [2*DATA_W-1:0] pr);
    logic [2*DATA_W-1:0] sh;
    sh = pr >>> FRAC;
    if (SAT_EN && !((&sh[2*DATA_W-1:DATA_W-1]) || !(|sh[2*DATA_W-1:DATA_W-1])))
      return sh[2*DATA_W-1] ? MINV : MAXV;
    return sh[DATA_W-1:0];
  endfunction

  assign grad_acc  = bus.grad_valid && bus.grad_ready;
  assign grad_ok   = grad_acc && (bus.grad_idx < NP);
  assign s1_go     = (state_q == APPLY) && (cnt_q < NP);
  assign sweep_end = (state_q == APPLY) && (cnt_q == NP + 4'd1);
  assign k_rd      = s1_go ? cnt_q : 4'd0;

  // Sign-extend both operands to full width so the low 2*DATA_W product bits are the signed product.
  assign prod = {{DATA_W{bus.lr[DATA_W-1]}}, bus.lr} * {{DATA_W{acc_q[k_rd][DATA_W-1]}}, acc_q[k_rd]};
  assign p_d  = narrow($signed(prod));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.apply_req) state_d = APPLY;
               else if (grad_ok)  state_d = ACCUM;
      ACCUM:   if (bus.apply_req) state_d = APPLY;
      APPLY:   if (sweep_end)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.grad_ready = (state_q != APPLY);
  assign bus.busy       = (state_q == APPLY);
  assign bus.done       = done_q;
  assign bus.err_idx    = err_q;
  assign bus.grad_count = gcnt_q;
  assign bus.param_flat = param_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      param_q  <= '0;
      acc_q    <= '0;
      gcnt_q   <= '0;
      cnt_q    <= '0;
      widx_q   <= '0;
      p_q      <= '0;
      s1_vld_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= sweep_end;
      err_q    <= grad_acc && !grad_ok;
      cnt_q    <= (state_q == APPLY) ? cnt_q + 4'd1 : 4'd0;
      s1_vld_q <= s1_go;
      widx_q   <= cnt_q;
      p_q      <= p_d;
      if (grad_ok) begin
        acc_q[bus.grad_idx] <= fit({acc_q[bus.grad_idx][DATA_W-1], acc_q[bus.grad_idx]}
                                 + {bus.grad_data[DATA_W-1], bus.grad_data});
        if (gcnt_q != 16'hFFFF) gcnt_q <= gcnt_q + 16'd1;
      end
      if (sweep_end) gcnt_q <= '0;
      if (bus.load_valid && (state_q != APPLY) && (bus.load_idx < NP))
        param_q[bus.load_idx] <= bus.load_data;
      // Stage 2: loads are blocked in APPLY, so this write never collides with a preload.
      if (s1_vld_q) begin
        param_q[widx_q] <= fit({param_q[widx_q][DATA_W-1], param_q[widx_q]} - {p_q[DATA_W-1], p_q});
        acc_q[widx_q]   <= '0;
      end
    end
  end
endmodule

// File: doc/lstm_weight_update.md
LSTM_WEIGHT_UPDATE -- requirements
Module: lstm_weight_update

Interface
REQ-001 SHALL use parameters: DATA_W, 32, Q16.16 word width; FRAC, 16, fraction bits; N_PARAM, 12, params (idx 0-7 = W_f[0],W_f[1],W_i[0],W_i[1],W_c[0],W_c[1],W_o[0],W_o[1]; idx 8-11 = b_f,b_i,b_c,b_o).
REQ-002 SHALL have clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have grad_valid  in  1  gradient offered; grad_ready  out  1  gradient accepted when both high.
REQ-005 SHALL have grad_idx  in  4  target param; grad_data  in  32  signed Q16.16 gradient.
REQ-006 SHALL have load_valid  in  1  param preload strobe; load_idx  in  4; load_data  in  32  signed Q16.16.
REQ-007 SHALL have lr  in  32  signed Q16.16 learning rate, sampled per sweep step.
REQ-008 SHALL have apply_req  in  1  start update sweep.
REQ-009 SHALL have param_flat  out  384  params, idx k at bits [32k+31:32k], registered.
REQ-010 SHALL have busy  out  1; done  out  1 one-cycle pulse; err_idx  out  1 one-cycle pulse; grad_count  out  16  grads accepted this batch.

Function
REQ-011 SHALL implement FSM states IDLE, ACCUM, APPLY.
REQ-012 grad_ready SHALL be 1 in IDLE/ACCUM, 0 in APPLY.
REQ-013 Accepted grad with idx<12: acc[idx] <= acc[idx]+grad_data at that edge; grad_count +1 (holds at 65535); IDLE->ACCUM.
REQ-014 Accepted grad with idx>=12: no acc/count change; err_idx pulses next cycle.
REQ-015 load_valid with idx<12 outside APPLY: param[idx] <= load_data; load in APPLY or idx>=12 ignored (no err).
REQ-016 apply_req in IDLE/ACCUM at edge t: state APPLY, busy=1 from t+1; apply_req in APPLY ignored.
REQ-017 Grad accepted on same edge as apply_req SHALL be included in that sweep.
REQ-018 Sweep SHALL be 2-stage pipeline: stage1 k=0..11 at t+1..t+12 computes p=(lr*acc[k]) 64-bit signed, arithmetic >>FRAC (floor); stage2 writes param[k] <= param[k]-p and acc[k] <= 0 one cycle later (t+2..t+13).
REQ-019 At t+14: done=1 for one cycle, busy=0, grad_count=0, state IDLE.
REQ-020 apply_req in IDLE (all acc zero) SHALL still run full sweep and pulse done; params unchanged.
REQ-021 param_flat SHALL reflect writes the cycle after each write edge.

Reset
REQ-022 rst SHALL immediately clear all params, acc, grad_count to 0, state IDLE, busy/done/err_idx 0, grad_ready 1 after release.
REQ-023 rst mid-APPLY SHALL abort sweep with no done pulse; partially written params are cleared.

Configuration
REQ-024 Macro LSTM_WU_SAT_EN defined: acc add, >>FRAC product narrowing, and param subtract SHALL saturate to 0x7FFF_FFFF / 0x8000_0000.
REQ-025 LSTM_WU_SAT_EN undefined: same operations SHALL wrap (keep low 32 bits); no other behaviour differs.

Verification
REQ-026 Load param0=0x0001_0000, lr=0x0000_8000, grads idx0 0x0001_0000 x2, apply -> grad_count=2 before, param0=0x0000_0000, done exactly 14 cycles after apply edge, grad_count=0.
REQ-027 Load param3=0x7FFF_0000, lr=0x0001_0000, grad idx3 0xFFFF_0000, apply -> param3=0x7FFF_FFFF with LSTM_WU_SAT_EN, 0x8000_0000 without.
REQ-028 Grad idx=12 data 0x0001_0000 -> err_idx pulse, grad_count unchanged, all param_flat unchanged after apply.
REQ-029 grad_valid held during APPLY -> grad_ready=0 until done cycle; grad accepted after, grad_count=1, not applied in current sweep.
REQ-030 lr=0x0000_8000, grad idx5 0xFFFF_FFFF, param5=0, apply -> param5=0x0000_0001 (floor rounding).
REQ-031 Assert rst at t+6 of a sweep -> param_flat all 0, busy=0, no done pulse, next apply completes normally.
